// File: rtl/sram_arbiter_pkg.sv
// Shared types for the pixel SRAM arbiter: FSM states and access-owner encoding.
package sram_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        READ    = 2'd1,
        WRITE   = 2'd2,
        RECOVER = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        OWN_VID  = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_FIFO = 2'd2
    } owner_e;

endpackage

// File: rtl/sram_arbiter.sv
// Arbitrates video reads, CPU reads and write-FIFO drains onto one async SRAM
// through a fixed-length IDLE -> READ/WRITE -> RECOVER access sequence.
module sram_arbiter
    import sram_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 17,
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned RD_CYCLES   = 2,
    parameter int unsigned WR_CYCLES   = 2,
    parameter int unsigned FIFO_SETTLE = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] fifo_addr,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic                  vid_req,
    input  logic [ADDR_WIDTH-1:0] vid_addr,
    output logic [DATA_WIDTH-1:0] vid_data,
    output logic                  vid_valid,
    input  logic                  cpu_rd_req,
    input  logic [ADDR_WIDTH-1:0] cpu_rd_addr,
    output logic [DATA_WIDTH-1:0] cpu_rd_data,
    output logic                  cpu_rd_valid,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [DATA_WIDTH-1:0] sram_dq_out,
    input  logic [DATA_WIDTH-1:0] sram_dq_in,
    output logic                  sram_dq_oe,
    output logic                  sram_cs_n,
    output logic                  sram_oe_n,
    output logic                  sram_we_n,
    output logic                  busy
);

    localparam int unsigned PHASE_MAX = (RD_CYCLES > WR_CYCLES) ? RD_CYCLES : WR_CYCLES;
    localparam int unsigned PW        = $clog2(PHASE_MAX + 1);
    localparam int unsigned SW        = $clog2(FIFO_SETTLE + 1);
    localparam logic [PW-1:0] RD_LAST = PW'(RD_CYCLES - 1);
    localparam logic [PW-1:0] WR_LAST = PW'(WR_CYCLES - 1);
    localparam logic [SW-1:0] SETTLE  = SW'(FIFO_SETTLE);

    state_e          state_q, state_d;
    owner_e          owner_q, owner_d;
    logic [PW-1:0]   phase_q, phase_d;
    logic [SW-1:0]   empty_cnt_q, empty_cnt_d;
    logic [SW-1:0]   full_cnt_q, full_cnt_d;

    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] dq_out_q, dq_out_d;
    logic [DATA_WIDTH-1:0] vid_data_q, vid_data_d;
    logic [DATA_WIDTH-1:0] cpu_data_q, cpu_data_d;
    logic dq_oe_q, dq_oe_d, cs_n_q, cs_n_d, oe_n_q, oe_n_d, we_n_q, we_n_d;
    logic rd_en_q, rd_en_d, vid_valid_q, vid_valid_d, cpu_valid_q, cpu_valid_d;
    logic busy_q, busy_d;

    logic idle, cpu_ok, fifo_ok, grant_vid, grant_cpu, grant_fifo;

    // CPU reads wait for a settled-empty FIFO so they always see prior writes.
    always_comb begin
        idle       = (state_q == IDLE);
        cpu_ok     = (empty_cnt_q == SETTLE) && fifo_empty;
        fifo_ok    = (full_cnt_q == SETTLE) && !fifo_empty;
        grant_vid  = idle && vid_req;
        grant_cpu  = idle && !vid_req && cpu_rd_req && cpu_ok;
        grant_fifo = idle && !vid_req && !grant_cpu && fifo_ok;
    end

    always_comb begin
        empty_cnt_d = '0;
        full_cnt_d  = '0;
        if (fifo_empty) begin
            empty_cnt_d = (empty_cnt_q == SETTLE) ? SETTLE : empty_cnt_q + SW'(1);
        end else if (!rd_en_q) begin
            full_cnt_d = (full_cnt_q == SETTLE) ? SETTLE : full_cnt_q + SW'(1);
        end
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            owner_q <= OWN_VID;
            phase_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            phase_q <= phase_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        phase_d = '0;
        unique case (state_q)
            IDLE: begin
                if (grant_vid) begin
                    state_d = READ;
                    owner_d = OWN_VID;
                end else if (grant_cpu) begin
                    state_d = READ;
                    owner_d = OWN_CPU;
                end else if (grant_fifo) begin
                    state_d = WRITE;
                    owner_d = OWN_FIFO;
                end
            end
            READ: begin
                if (phase_q == RD_LAST) state_d = RECOVER;
                else                    phase_d = phase_q + PW'(1);
            end
            WRITE: begin
                if (phase_q == WR_LAST) state_d = RECOVER;
                else                    phase_d = phase_q + PW'(1);
            end
            RECOVER: state_d = IDLE;
        endcase
    end

    // Output logic: next values of the registered SRAM pins and completions
    always_comb begin
        addr_d      = addr_q;
        dq_out_d    = dq_out_q;
        dq_oe_d     = dq_oe_q;
        cs_n_d      = cs_n_q;
        oe_n_d      = oe_n_q;
        we_n_d      = we_n_q;
        vid_data_d  = vid_data_q;
        cpu_data_d  = cpu_data_q;
        rd_en_d     = 1'b0;
        vid_valid_d = 1'b0;
        cpu_valid_d = 1'b0;
        busy_d      = (state_d != IDLE);
        unique case (state_q)
            IDLE: begin
                if (grant_vid || grant_cpu) begin
                    addr_d  = grant_vid ? vid_addr : cpu_rd_addr;
                    dq_oe_d = 1'b0;
                    cs_n_d  = 1'b0;
                    oe_n_d  = 1'b0;
                end else if (grant_fifo) begin
                    addr_d   = fifo_addr;
                    dq_out_d = fifo_data;
                    dq_oe_d  = 1'b1;
                    cs_n_d   = 1'b0;
                    we_n_d   = 1'b0;
                    rd_en_d  = 1'b1;
                end
            end
            READ: begin
                if (phase_q == RD_LAST) begin
                    cs_n_d = 1'b1;
                    oe_n_d = 1'b1;
                    if (owner_q == OWN_VID) begin
                        vid_valid_d = 1'b1;
                        vid_data_d  = sram_dq_in;
                    end else begin
                        cpu_valid_d = 1'b1;
                        cpu_data_d  = sram_dq_in;
                    end
                end
            end
            WRITE: begin
                // Address, data and DQ drive stay put through RECOVER for hold time.
                if (phase_q == WR_LAST) begin
                    we_n_d = 1'b1;
                    cs_n_d = 1'b1;
                end
            end
            RECOVER: dq_oe_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            empty_cnt_q <= '0;
            full_cnt_q  <= '0;
            addr_q      <= '0;
            dq_out_q    <= '0;
            vid_data_q  <= '0;
            cpu_data_q  <= '0;
            dq_oe_q     <= 1'b0;
            cs_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
            we_n_q      <= 1'b1;
            rd_en_q     <= 1'b0;
            vid_valid_q <= 1'b0;
            cpu_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            empty_cnt_q <= empty_cnt_d;
            full_cnt_q  <= full_cnt_d;
            addr_q      <= addr_d;
            dq_out_q    <= dq_out_d;
            vid_data_q  <= vid_data_d;
            cpu_data_q  <= cpu_data_d;
            dq_oe_q     <= dq_oe_d;
            cs_n_q      <= cs_n_d;
            oe_n_q      <= oe_n_d;
            we_n_q      <= we_n_d;
            rd_en_q     <= rd_en_d;
            vid_valid_q <= vid_valid_d;
            cpu_valid_q <= cpu_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign fifo_rd_en   = rd_en_q;
    assign vid_data     = vid_data_q;
    assign vid_valid    = vid_valid_q;
    assign cpu_rd_data  = cpu_data_q;
    assign cpu_rd_valid = cpu_valid_q;
    assign sram_addr    = addr_q;
    assign sram_dq_out  = dq_out_q;
    assign sram_dq_oe   = dq_oe_q;
    assign sram_cs_n    = cs_n_q;
    assign sram_oe_n    = oe_n_q;
    assign sram_we_n    = we_n_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Scoreboard bench for sram_arbiter: SRAM and FIFO models, requester tasks,
// and a negedge monitor that checks completions and writes against queued expectations.
module tb_sram_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [16:0] fifo_addr = '0;
    logic [7:0]  fifo_data = '0;
    logic        fifo_empty = 1'b1;
    logic        fifo_rd_en;
    logic        vid_req = 1'b0;
    logic [16:0] vid_addr = '0;
    logic [7:0]  vid_data;
    logic        vid_valid;
    logic        cpu_rd_req = 1'b0;
    logic [16:0] cpu_rd_addr = '0;
    logic [7:0]  cpu_rd_data;
    logic        cpu_rd_valid;
    logic [16:0] sram_addr;
    logic [7:0]  sram_dq_out;
    logic [7:0]  sram_dq_in;
    logic        sram_dq_oe, sram_cs_n, sram_oe_n, sram_we_n, busy;

    int vectors = 0;
    int errors  = 0;

    bit [7:0]    mem [0:(1<<17)-1];
    logic [24:0] fq[$];
    logic [24:0] wr_q[$];
    logic [7:0]  vid_q[$];
    logic [7:0]  cpu_q[$];
    string       order_log = "";
    int          pops = 0;

    sram_arbiter dut (
        .clk(clk), .reset(reset),
        .fifo_addr(fifo_addr), .fifo_data(fifo_data), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_data(vid_data), .vid_valid(vid_valid),
        .cpu_rd_req(cpu_rd_req), .cpu_rd_addr(cpu_rd_addr), .cpu_rd_data(cpu_rd_data),
        .cpu_rd_valid(cpu_rd_valid),
        .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_in(sram_dq_in),
        .sram_dq_oe(sram_dq_oe), .sram_cs_n(sram_cs_n), .sram_oe_n(sram_oe_n),
        .sram_we_n(sram_we_n), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // SRAM model: reads while selected and output-enabled, writes while strobed
    assign sram_dq_in = (!sram_cs_n && !sram_oe_n) ? mem[sram_addr] : 8'h00;
    always @(posedge clk) begin
        if (!sram_cs_n && !sram_we_n && sram_dq_oe) mem[sram_addr] <= sram_dq_out;
    end

    // FIFO model: pop on the observed strobe, then present the new head
    always @(negedge clk) begin
        if (fifo_rd_en && !reset && fq.size() != 0) void'(fq.pop_front());
        fifo_empty = (fq.size() == 0);
        if (fq.size() != 0) {fifo_addr, fifo_data} = fq[0];
    end

    // Monitor / scoreboard
    int  cycle = 0;
    int  last_pop = -100;
    int  we_run = 0;
    logic prev_vv = 1'b0, prev_cv = 1'b0;
    always @(negedge clk) begin
        if (reset) begin
            we_run  = 0;
            prev_vv = 1'b0;
            prev_cv = 1'b0;
        end else begin
            if (vid_valid) begin
                check("vid_valid_single_cycle", 32'(prev_vv), 32'd0);
                if (vid_q.size() == 0) check("vid_unexpected_valid", 32'd1, 32'd0);
                else check("vid_data", 32'(vid_data), 32'(vid_q.pop_front()));
                order_log = {order_log, "V"};
            end
            if (cpu_rd_valid) begin
                check("cpu_valid_single_cycle", 32'(prev_cv), 32'd0);
                if (cpu_q.size() == 0) check("cpu_unexpected_valid", 32'd1, 32'd0);
                else check("cpu_rd_data", 32'(cpu_rd_data), 32'(cpu_q.pop_front()));
                order_log = {order_log, "C"};
            end
            if (fifo_rd_en) begin
                pops++;
                check("pop_spacing_ge4", 32'(cycle - last_pop >= 4), 32'd1);
                last_pop = cycle;
                check("write_strobes", {29'd0, sram_cs_n, sram_we_n, sram_dq_oe}, 32'd1);
                if (wr_q.size() == 0) check("write_unexpected_pop", 32'd1, 32'd0);
                else check("write_addr_data", 32'({sram_addr, sram_dq_out}), 32'(wr_q.pop_front()));
                order_log = {order_log, "W"};
            end
            if (!sram_we_n) we_run++;
            else if (we_run != 0) begin
                check("we_n_low_cycles", 32'(we_run), 32'd2);
                we_run = 0;
            end
            prev_vv = vid_valid;
            prev_cv = cpu_rd_valid;
        end
        cycle++;
    end

    task automatic fifo_push(input logic [16:0] a, input logic [7:0] d);
        fq.push_back({a, d});
        wr_q.push_back({a, d});
    endtask

    task automatic vid_read(input logic [16:0] a, input logic [7:0] exp);
        bit seen = 0;
        vid_addr = a;
        vid_req  = 1'b1;
        vid_q.push_back(exp);
        for (int n = 0; n < 60 && !seen; n++) begin
            @(negedge clk);
            seen = vid_valid;
        end
        vid_req = 1'b0;
        if (!seen) check("vid_timeout", 32'd0, 32'd1);
    endtask

    task automatic cpu_read(input logic [16:0] a, input logic [7:0] exp);
        bit seen = 0;
        cpu_rd_addr = a;
        cpu_rd_req  = 1'b1;
        cpu_q.push_back(exp);
        for (int n = 0; n < 60 && !seen; n++) begin
            @(negedge clk);
            seen = cpu_rd_valid;
        end
        cpu_rd_req = 1'b0;
        if (!seen) check("cpu_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_quiet();
        bit done = 0;
        for (int n = 0; n < 100 && !done; n++) begin
            @(negedge clk);
            done = fifo_empty && !busy && (fq.size() == 0) && (wr_q.size() == 0)
                   && (vid_q.size() == 0) && (cpu_q.size() == 0);
        end
        if (!done) check("drain_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [3:0] oe_pat, vv_pat;
        int         pops0;

        mem[17'h1ABCD] <= 8'h5A;
        mem[17'h00100] <= 8'hC3;

        // Reset, then idle
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_strobes", {28'd0, sram_cs_n, sram_oe_n, sram_we_n, sram_dq_oe}, 32'he);
        check("rst_busy_rd_en_valids", {28'd0, busy, fifo_rd_en, vid_valid, cpu_rd_valid}, 32'd0);
        check("rst_addr", 32'(sram_addr), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (4) @(negedge clk);
        check("idle_strobes", {27'd0, busy, sram_cs_n, sram_oe_n, sram_we_n, sram_dq_oe}, 32'he);

        // Single video read with cycle-accurate strobe/valid timing
        @(posedge clk); #1;
        vid_addr = 17'h1ABCD;
        vid_req  = 1'b1;
        vid_q.push_back(8'h5A);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            oe_pat[i] = sram_oe_n;
            vv_pat[i] = vid_valid;
        end
        vid_req = 1'b0;
        check("vid_oe_n_pattern", 32'(oe_pat), 32'b1001);
        check("vid_valid_pattern", 32'(vv_pat), 32'b1000);
        check("vid_sram_addr", 32'(sram_addr), 32'h1ABCD);
        wait_quiet();

        // Two FIFO writes
        pops0 = pops;
        @(posedge clk); #1;
        fifo_push(17'h00010, 8'h11);
        fifo_push(17'h00011, 8'h22);
        wait_quiet();
        check("fifo_pop_count", 32'(pops - pops0), 32'd2);
        check("mem_0x10", 32'(mem[17'h00010]), 32'h11);
        check("mem_0x11", 32'(mem[17'h00011]), 32'h22);

        // CPU read-after-write coherency
        @(posedge clk); #1;
        fifo_push(17'h00010, 8'h77);
        cpu_read(17'h00010, 8'h77);
        wait_quiet();
        check("mem_0x10_after", 32'(mem[17'h00010]), 32'h77);

        // All three requesters at once
        order_log = "";
        @(posedge clk); #1;
        fifo_push(17'h00020, 8'h33);
        fork
            vid_read(17'h00100, 8'hC3);
            cpu_read(17'h00020, 8'h33);
        join
        wait_quiet();
        vectors++;
        if (order_log != "VWC") begin
            errors++;
            $display("FAIL grant_order: got %s expected VWC", order_log);
        end

        // Reset during WRITE: popped entry lost, next entry serviced
        @(posedge clk); #1;
        fq.push_back({17'h00030, 8'h44});
        wr_q.push_back({17'h00030, 8'h44});
        fifo_push(17'h00031, 8'h55);
        begin
            bit seen = 0;
            for (int n = 0; n < 40 && !seen; n++) begin
                @(negedge clk);
                seen = fifo_rd_en;
            end
            if (!seen) check("write_start_timeout", 32'd0, 32'd1);
        end
        #1 reset = 1'b1;
        #1;
        check("async_rst_strobes", {28'd0, sram_cs_n, sram_oe_n, sram_we_n, sram_dq_oe}, 32'he);
        check("async_rst_busy", 32'(busy), 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("post_rst_idle", {28'd0, busy, sram_cs_n, sram_we_n, sram_dq_oe}, 32'h6);
        wait_quiet();
        check("mem_0x30_aborted", 32'(mem[17'h00030]), 32'h00);
        check("mem_0x31", 32'(mem[17'h00031]), 32'h55);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
